// File: rtl/sam_con_mc.sv
// Strided ternary-kernel convolution: NUM_FILT filters share one sliding sample window.
// Optional output clamping with Sat_Flag is enabled by defining SAM_CON_SAT_EN.
module sam_con_mc #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_K    = 16,
  parameter int unsigned NUM_FILT = 4,
  parameter int unsigned OUT_W    = 32
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         Cfg_Load,
  input  logic [7:0]                   STRIDE,
  input  logic [7:0]                   KERNEL_SIZE,
  output logic                         Cfg_Err,
  input  logic                         Kernel_Valid,
  input  logic [2*NUM_FILT-1:0]        Kernel_In,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [DATA_W-1:0]            Data_In,
  input  logic                         In_Last,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [NUM_FILT*OUT_W-1:0]    Data_Out,
  output logic                         Out_Last,
  output logic [NUM_FILT-1:0]          Sat_Flag,
  output logic                         Done
);

  localparam int unsigned ACC_W = DATA_W + $clog2(MAX_K) + 1;

  typedef enum logic [2:0] {IDLE, KLOAD, FILL, RUN, DONE} state_t;

  state_t                      state, state_n;
  logic [7:0]                  k_q, k_n, stride_q, stride_n, cnt_q, cnt_n;
  logic                        cfg_err_q, cfg_err_n;
  logic                        cfg_bad, accept, trigger, clr_cfg, tap_shift;
  logic                        out_valid_q, out_last_q;
  logic [NUM_FILT*OUT_W-1:0]   data_q, y_c;
  logic [NUM_FILT-1:0]         sat_q, sat_c;
  logic signed [DATA_W-1:0]    win   [MAX_K];
  logic signed [DATA_W-1:0]    win_n [MAX_K];
  logic [2*NUM_FILT-1:0]       taps  [MAX_K];
  logic signed [ACC_W-1:0]     acc_c [NUM_FILT];

  assign In_Ready  = ((state == FILL) || (state == RUN)) && !(out_valid_q && !Out_Ready);
  assign accept    = In_Valid && In_Ready;
  assign cfg_bad   = (KERNEL_SIZE < 8'd2) || ({1'b0, KERNEL_SIZE} > 9'(MAX_K)) || (STRIDE == 8'd0);
  assign Cfg_Err   = cfg_err_q;
  assign Done      = (state == DONE);
  assign Out_Valid = out_valid_q;
  assign Out_Last  = out_last_q;
  assign Data_Out  = data_q;
  assign Sat_Flag  = sat_q;

  // State and configuration registers
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      k_q       <= '0;
      stride_q  <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      k_q       <= k_n;
      stride_q  <= stride_n;
      cnt_q     <= cnt_n;
      cfg_err_q <= cfg_err_n;
    end
  end

  // Next state: cnt counts taps in KLOAD, samples in FILL, stride phase in RUN
  always_comb begin
    state_n   = state;
    k_n       = k_q;
    stride_n  = stride_q;
    cnt_n     = cnt_q;
    cfg_err_n = cfg_err_q;
    trigger   = 1'b0;
    clr_cfg   = 1'b0;
    tap_shift = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (Cfg_Load) begin
          k_n      = KERNEL_SIZE;
          stride_n = STRIDE;
          cnt_n    = '0;
          clr_cfg  = 1'b1;
          if (cfg_bad) begin
            cfg_err_n = 1'b1;
            state_n   = IDLE;
          end else begin
            cfg_err_n = 1'b0;
            state_n   = KLOAD;
          end
        end
      end
      KLOAD: begin
        if (Kernel_Valid) begin
          tap_shift = 1'b1;
          if (cnt_q == k_q - 8'd1) begin
            cnt_n   = '0;
            state_n = FILL;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          if (cnt_q == k_q - 8'd1) begin
            trigger = 1'b1;
            cnt_n   = '0;
            state_n = RUN;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
          if (In_Last) state_n = DONE;
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_q == stride_q - 8'd1) begin
            trigger = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + 8'd1;
          end
          if (In_Last) state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Window after this cycle's sample: index 0 newest
  always_comb begin
    win_n[0] = Data_In;
    for (int j = 1; j < MAX_K; j++) win_n[j] = win[j-1];
  end

  // Taps are shifted in the same direction, so taps[j] pairs with win_n[j]; unloaded taps stay 0
  always_comb begin
    for (int f = 0; f < NUM_FILT; f++) begin
      acc_c[f] = '0;
      for (int j = 0; j < MAX_K; j++) begin
        case (taps[j][2*f +: 2])
          2'b01:   acc_c[f] = acc_c[f] + ACC_W'(win_n[j]);
          2'b11:   acc_c[f] = acc_c[f] - ACC_W'(win_n[j]);
          default: ;
        endcase
      end
    end
  end

`ifdef SAM_CON_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    y_c   = '0;
    sat_c = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      if (acc_c[f] > SAT_MAX) begin
        y_c[f*OUT_W +: OUT_W] = OUT_W'(SAT_MAX);
        sat_c[f]              = 1'b1;
      end else if (acc_c[f] < SAT_MIN) begin
        y_c[f*OUT_W +: OUT_W] = OUT_W'(SAT_MIN);
        sat_c[f]              = 1'b1;
      end else begin
        y_c[f*OUT_W +: OUT_W] = OUT_W'(acc_c[f]);
      end
    end
  end
`else
  always_comb begin
    y_c   = '0;
    sat_c = '0;
    for (int f = 0; f < NUM_FILT; f++) y_c[f*OUT_W +: OUT_W] = OUT_W'(acc_c[f]);
  end
`endif

  // Window, taps and output register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int j = 0; j < MAX_K; j++) begin
        win[j]  <= '0;
        taps[j] <= '0;
      end
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      data_q      <= '0;
      sat_q       <= '0;
    end else begin
      if (clr_cfg) begin
        for (int j = 0; j < MAX_K; j++) begin
          win[j]  <= '0;
          taps[j] <= '0;
        end
      end else begin
        if (tap_shift) begin
          taps[0] <= Kernel_In;
          for (int j = 1; j < MAX_K; j++) taps[j] <= taps[j-1];
        end
        if (accept) begin
          for (int j = 0; j < MAX_K; j++) win[j] <= win_n[j];
        end
      end
      if (trigger) begin
        out_valid_q <= 1'b1;
        out_last_q  <= In_Last;
        data_q      <= y_c;
        sat_q       <= sat_c;
      end else if (Out_Ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sam_con_mc.sv
// Directed bench for sam_con_mc: config table, streaming scenario table, stall, reset and saturation sequences.
module tb_sam_con_mc;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Cfg_Load, Kernel_Valid, In_Valid, In_Last, Out_Ready;
  logic [7:0]   STRIDE, KERNEL_SIZE, Kernel_In;
  logic [31:0]  Data_In;
  logic         Cfg_Err, In_Ready, Out_Valid, Out_Last, Done;
  logic [127:0] Data_Out;
  logic [3:0]   Sat_Flag;

  logic         cl8, kv8, iv8, il8, ordy8, err8, ir8, ov8, olast8, done8;
  logic [7:0]   ks8, st8, din8, dout8;
  logic [1:0]   kin8;
  logic [0:0]   sat8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [127:0] beat_d[$];
  bit           beat_l[$];
  int           beat_c[$];
  int           acc_q[$];

  sam_con_mc dut (
    .Clk(Clk), .Rst(Rst), .Cfg_Load(Cfg_Load), .STRIDE(STRIDE), .KERNEL_SIZE(KERNEL_SIZE),
    .Cfg_Err(Cfg_Err), .Kernel_Valid(Kernel_Valid), .Kernel_In(Kernel_In), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Data_In(Data_In), .In_Last(In_Last), .Out_Valid(Out_Valid),
    .Out_Ready(Out_Ready), .Data_Out(Data_Out), .Out_Last(Out_Last), .Sat_Flag(Sat_Flag), .Done(Done)
  );

  sam_con_mc #(.DATA_W(8), .MAX_K(4), .NUM_FILT(1), .OUT_W(8)) dut8 (
    .Clk(Clk), .Rst(Rst), .Cfg_Load(cl8), .STRIDE(st8), .KERNEL_SIZE(ks8), .Cfg_Err(err8),
    .Kernel_Valid(kv8), .Kernel_In(kin8), .In_Valid(iv8), .In_Ready(ir8), .Data_In(din8),
    .In_Last(il8), .Out_Valid(ov8), .Out_Ready(ordy8), .Data_Out(dout8), .Out_Last(olast8),
    .Sat_Flag(sat8), .Done(done8)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Handshake monitor, sampled mid-cycle
  always @(negedge Clk) begin
    if (mon_en) begin
      if (In_Valid && In_Ready) acc_q.push_back(cyc);
      if (Out_Valid && Out_Ready) begin
        beat_d.push_back(Data_Out);
        beat_l.push_back(Out_Last);
        beat_c.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int ks; int st; bit rst; bit err;
  } cfg_t;

  typedef struct {
    int k; int stride; logic [7:0] kern [4]; int base; int step; int nsamp; bit last;
    int nexp; int expv [16]; bit last_beat;
  } scen_t;

  cfg_t  cv [7];
  scen_t sc [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_zero(input string p);
    chk({p, "_ov"}, Out_Valid, 0);
    chk({p, "_dout_nz"}, int'(Data_Out != '0), 0);
    chk({p, "_olast"}, Out_Last, 0);
    chk({p, "_sat"}, Sat_Flag, 0);
    chk({p, "_done"}, Done, 0);
    chk({p, "_err"}, Cfg_Err, 0);
    chk({p, "_ready"}, In_Ready, 0);
  endtask

  task automatic do_reset();
    Rst = 1'b1; Cfg_Load = 0; Kernel_Valid = 0; In_Valid = 0; In_Last = 0; Out_Ready = 1;
    repeat (2) tick();
    chk_zero("rst");
    Rst = 1'b0;
    tick();
  endtask

  task automatic cfg(input int ks, input int st);
    Cfg_Load = 1'b1; KERNEL_SIZE = 8'(ks); STRIDE = 8'(st);
    tick();
    Cfg_Load = 1'b0;
  endtask

  task automatic load_kernel(input int id);
    for (int t = 0; t < sc[id].k; t++) begin
      Kernel_Valid = 1'b1; Kernel_In = sc[id].kern[t];
      tick();
      Kernel_Valid = 1'b0; Kernel_In = 8'hFF;
      tick();
    end
  endtask

  task automatic send_sample(input int v, input bit last);
    int guard = 0;
    In_Valid = 1'b1; Data_In = 32'(v); In_Last = last;
    #1;
    while (!In_Ready && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("in_ready_timeout", guard, 0);
    tick();
    In_Valid = 1'b0; In_Last = 1'b0;
  endtask

  task automatic mon_start();
    beat_d.delete(); beat_l.delete(); beat_c.delete(); acc_q.delete();
    mon_en = 1'b1;
  endtask

  task automatic run_scen(input int id, input bit do_rst);
    logic [127:0] d;
    int idx;
    if (do_rst) do_reset();
    Out_Ready = 1'b1;
    cfg(sc[id].k, sc[id].stride);
    chk($sformatf("s%0d_cfg_err", id), Cfg_Err, 0);
    load_kernel(id);
    mon_start();
    for (int i = 0; i < sc[id].nsamp; i++)
      send_sample(sc[id].base + i * sc[id].step, sc[id].last && (i == sc[id].nsamp - 1));
    repeat (3) tick();
    mon_en = 1'b0;
    chk($sformatf("s%0d_beats", id), beat_d.size(), sc[id].nexp);
    for (int b = 0; b < sc[id].nexp && b < beat_d.size(); b++) begin
      d = beat_d[b];
      for (int f = 0; f < 4; f++)
        chk($sformatf("s%0d_y%0d_f%0d", id, b, f), int'($signed(d[f*32 +: 32])), sc[id].expv[b*4+f]);
      chk($sformatf("s%0d_last%0d", id, b), beat_l[b], int'(sc[id].last_beat && (b == sc[id].nexp - 1)));
      idx = sc[id].k - 1 + b * sc[id].stride;
      if (idx < acc_q.size()) chk($sformatf("s%0d_lat%0d", id, b), beat_c[b] - acc_q[idx], 1);
    end
    chk($sformatf("s%0d_done", id), Done, int'(sc[id].last));
    chk($sformatf("s%0d_ready_end", id), In_Ready, int'(!sc[id].last));
    chk($sformatf("s%0d_drained", id), Out_Valid, 0);
  endtask

  initial begin
    int sv [4];
    int ey [3];
    int es [3];
    logic [127:0] d;

    cv[0] = '{0, 1, 1, 1};
    cv[1] = '{17, 1, 0, 1};
    cv[2] = '{3, 0, 0, 1};
    cv[3] = '{16, 1, 0, 0};
    cv[4] = '{1, 5, 0, 0};
    cv[5] = '{2, 0, 1, 1};
    cv[6] = '{2, 255, 0, 0};

    sc[0].k = 3; sc[0].stride = 1; sc[0].kern = '{8'hB5, 8'h74, 8'h37, 8'h00};
    sc[0].base = 1; sc[0].step = 1; sc[0].nsamp = 6; sc[0].last = 0; sc[0].nexp = 4;
    sc[0].expv = '{-2, 6, -6, 2, -2, 9, -9, 3, -2, 12, -12, 4, -2, 15, -15, 5}; sc[0].last_beat = 0;
    sc[1].k = 4; sc[1].stride = 2; sc[1].kern = '{8'h6D, 8'hED, 8'h6D, 8'hED};
    sc[1].base = 1; sc[1].step = 1; sc[1].nsamp = 8; sc[1].last = 1; sc[1].nexp = 3;
    sc[1].expv = '{10, -10, 0, -2, 18, -18, 0, -2, 26, -26, 0, -2, 0, 0, 0, 0}; sc[1].last_beat = 1;
    sc[2].k = 2; sc[2].stride = 3; sc[2].kern = '{8'h1D, 8'hC5, 8'h00, 8'h00};
    sc[2].base = 1; sc[2].step = 1; sc[2].nsamp = 6; sc[2].last = 1; sc[2].nexp = 2;
    sc[2].expv = '{3, 1, 1, -2, 9, 1, 4, -5, 0, 0, 0, 0, 0, 0, 0, 0}; sc[2].last_beat = 0;
    sc[3].k = 2; sc[3].stride = 1; sc[3].kern = '{8'h57, 8'h9F, 8'h00, 8'h00};
    sc[3].base = -5; sc[3].step = 3; sc[3].nsamp = 3; sc[3].last = 1; sc[3].nexp = 2;
    sc[3].expv = '{7, -3, -7, -5, 1, -3, -1, -2, 0, 0, 0, 0, 0, 0, 0, 0}; sc[3].last_beat = 1;

    cl8 = 0; kv8 = 0; iv8 = 0; il8 = 0; ordy8 = 1; ks8 = 0; st8 = 0; din8 = 0; kin8 = 0;
    STRIDE = 0; KERNEL_SIZE = 0; Kernel_In = 0; Data_In = 0;
    do_reset();

    // Configuration checks
    foreach (cv[i]) begin
      if (cv[i].rst) do_reset();
      cfg(cv[i].ks, cv[i].st);
      chk($sformatf("cfg%0d_err", i), Cfg_Err, int'(cv[i].err));
    end

    // Bad config keeps IDLE; the next good one is accepted
    do_reset();
    cfg(17, 1);
    chk("bad_then_err", Cfg_Err, 1);
    run_scen(2, 0);
    run_scen(0, 1);

    // Output stall
    do_reset();
    cfg(3, 1);
    load_kernel(0);
    mon_start();
    send_sample(1, 0);
    send_sample(2, 0);
    Out_Ready = 1'b0;
    send_sample(3, 0);
    In_Valid = 1'b1; Data_In = 32'd4;
    #1;
    for (int c = 0; c < 5; c++) begin
      d = Data_Out;
      chk($sformatf("stall%0d_ready", c), In_Ready, 0);
      chk($sformatf("stall%0d_ov", c), Out_Valid, 1);
      chk($sformatf("stall%0d_hold", c), int'($signed(d[63:32])), 6);
      tick();
    end
    Out_Ready = 1'b1;
    for (int i = 4; i <= 6; i++) send_sample(i, 0);
    repeat (3) tick();
    mon_en = 1'b0;
    chk("stall_beats", beat_d.size(), 4);
    for (int b = 0; b < 4 && b < beat_d.size(); b++) begin
      d = beat_d[b];
      chk($sformatf("stall_y%0d_f1", b), int'($signed(d[63:32])), 6 + 3 * b);
      chk($sformatf("stall_y%0d_f0", b), int'($signed(d[31:0])), -2);
    end

    // Reset in RUN with a pending output
    do_reset();
    cfg(3, 1);
    load_kernel(0);
    Out_Ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_sample(i, 0);
    chk("midrst_pending", Out_Valid, 1);
    Rst = 1'b1;
    tick();
    chk_zero("midrst");
    Rst = 1'b0;
    Out_Ready = 1'b1;
    tick();
    run_scen(1, 0);
    run_scen(3, 0);

    // Narrow instance: clamp or wrap
    sv = '{100, 100, -100, -100};
`ifdef SAM_CON_SAT_EN
    ey = '{127, 0, -128};
    es = '{1, 0, 1};
`else
    ey = '{-56, 0, 56};
    es = '{0, 0, 0};
`endif
    cl8 = 1'b1; ks8 = 8'd2; st8 = 8'd1;
    tick();
    cl8 = 1'b0;
    chk("n8_err", err8, 0);
    kv8 = 1'b1; kin8 = 2'b01;
    repeat (2) tick();
    kv8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv8 = 1'b1; din8 = 8'(sv[i]);
      #1;
      chk($sformatf("n8_ready%0d", i), ir8, 1);
      tick();
      if (i >= 1) begin
        chk($sformatf("n8_ov%0d", i), ov8, 1);
        chk($sformatf("n8_y%0d", i), int'($signed(dout8)), ey[i-1]);
        chk($sformatf("n8_sat%0d", i), sat8, es[i-1]);
      end
    end
    iv8 = 1'b0;
    chk("n8_last", olast8, 0);
    chk("n8_done", done8, 0);
    il8 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sam_con_mc.md
SAM_CON_MC -- requirements
Module: sam_con_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning signed sample width.
REQ-002 The block SHALL have parameter MAX_K, default 16, meaning maximum kernel taps (2..256).
REQ-003 The block SHALL have parameter NUM_FILT, default 4, meaning parallel ternary filters sharing one sample window.
REQ-004 The block SHALL have parameter OUT_W, default 32, meaning per-filter output width.
REQ-005 The block SHALL have ports as follows: Clk in 1 clock; Rst in 1 reset, synchronous, active-high, on Clk.
REQ-006 The block SHALL have ports as follows: Cfg_Load in 1 latch config; STRIDE in 8; KERNEL_SIZE in 8; Cfg_Err out 1.
REQ-007 The block SHALL have ports as follows: Kernel_Valid in 1; Kernel_In in 2*NUM_FILT, one tap per filter with filter f at bits [2f+1:2f].
REQ-008 The block SHALL have ports as follows: In_Valid in 1; In_Ready out 1; Data_In in DATA_W; In_Last in 1.
REQ-009 The block SHALL have ports as follows: Out_Valid out 1; Out_Ready in 1; Data_Out out NUM_FILT*OUT_W with filter f at slice f; Out_Last out 1; Sat_Flag out NUM_FILT; Done out 1.

Function
REQ-010 The FSM SHALL have states IDLE, KLOAD, FILL, RUN, DONE.
REQ-011 IDLE: Cfg_Load SHALL latch STRIDE/KERNEL_SIZE; if KERNEL_SIZE<2, KERNEL_SIZE>MAX_K or STRIDE==0, the block SHALL set Cfg_Err=1 and stay in IDLE; otherwise it SHALL clear Cfg_Err and go to KLOAD.
REQ-012 KLOAD: each Kernel_Valid cycle SHALL store one tap per filter, tap 0 first; after K taps the block SHALL go to FILL. Non-Kernel_Valid cycles SHALL be ignored.
REQ-013 Tap encoding SHALL be: 2'b01 = +1, 2'b11 = -1, 2'b00/2'b10 = 0.
REQ-014 A sample SHALL be accepted when In_Valid && In_Ready; In_Ready SHALL be 1 only in FILL/RUN and when !(Out_Valid && !Out_Ready).
REQ-015 Each accepted sample SHALL shift the window: W[0] oldest, W[K-1] newest.
REQ-016 FILL SHALL go to RUN on the K-th accepted sample, and that sample SHALL trigger an output.
REQ-017 In RUN, an output SHALL be triggered on every STRIDE-th accepted sample after the previous trigger; STRIDE=1 SHALL trigger on every sample.
REQ-018 Output SHALL be y_f = sum over i=0..K-1 of w_f[i]*W[i], with tap 0 on the oldest sample, computed at full precision (DATA_W+clog2(MAX_K)+1 bits), signed.
REQ-019 Latency: Out_Valid SHALL rise the cycle after the triggering sample is accepted; computation SHALL be single-cycle combinational into the output register.
REQ-020 While Out_Valid && !Out_Ready, Data_Out, Out_Last and Sat_Flag SHALL hold stable; Out_Valid SHALL clear on Out_Ready unless a new output loads in the same cycle.
REQ-021 An accepted sample with In_Last=1 SHALL move the FSM to DONE. If that sample triggers an output, the output SHALL carry Out_Last=1; otherwise no final beat SHALL be emitted and a partial window SHALL be discarded.
REQ-022 DONE: Done SHALL be 1 and In_Ready SHALL be 0; the pending output SHALL still drain; Cfg_Load SHALL restart the IDLE check and require a kernel reload.
REQ-023 Cfg_Load outside IDLE/DONE SHALL be ignored.

Reset
REQ-024 On Rst, the block SHALL go to IDLE and clear window, taps, counters, Out_Valid, Out_Last, Data_Out, Sat_Flag, Done and Cfg_Err to 0; In_Ready SHALL be 0.
REQ-025 Rst SHALL take priority over all inputs, mid-operation included, and SHALL discard any pending output.

Configuration
REQ-026 When SAM_CON_SAT_EN is defined, each y_f exceeding the signed OUT_W range SHALL clamp to the max/min value and set Sat_Flag[f] for that beat.
REQ-027 When SAM_CON_SAT_EN is undefined, y_f SHALL be truncated to its low OUT_W bits (two's-complement wrap) and Sat_Flag SHALL be tied 0.

Verification
REQ-028 K=3, STRIDE=1, filter0 taps {+1,0,-1}, samples 1..6, Out_Ready=1 -> outputs -2,-2,-2,-2 on 4 consecutive cycles, first beat one cycle after sample 3.
REQ-029 K=4, STRIDE=2, all taps +1, samples 1..8 with In_Last on 8 -> outputs 10,18,26; last beat carries Out_Last=1; Done=1.
REQ-030 K=3, STRIDE=1, Out_Ready=0 for 5 cycles after first beat -> In_Ready=0 and Data_Out held; on release, no sample is lost or duplicated.
REQ-031 KERNEL_SIZE=0 or 17 (MAX_K=16), or STRIDE=0 -> Cfg_Err=1 and state stays IDLE; a following valid Cfg_Load clears Cfg_Err.
REQ-032 SAT_EN defined, OUT_W=8, K=2, taps {+1,+1}, samples 100,100 -> Data_Out=127 and Sat_Flag=1; without SAT_EN -> -56 and Sat_Flag=0.
REQ-033 Rst asserted in RUN with Out_Valid=1 -> next cycle all outputs 0 and FSM in IDLE; a new Cfg_Load plus kernel reload then operates normally.
